// File: rtl/sha256d_nonce_collector.sv
// Golden-nonce collector: round-robin arbitration of core hits into a FWFT FIFO, plus interrupt source.
// Optional SHA256D_NC_TSTAMP_EN adds a 32-bit cycle timestamp per entry and a head_tstamp port.
module sha256d_nonce_collector #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned NONCE_W        = 32,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned IRQ_ACTIVE_LVL = 1
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic [NUM_CORES-1:0]          hit_valid,
    input  logic [NUM_CORES*NONCE_W-1:0]  hit_nonce,
    output logic [NUM_CORES-1:0]          hit_ready,
    input  logic                          pop,
    output logic [NONCE_W-1:0]            head_nonce,
    output logic [3:0]                    head_core,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underflow,
    input  logic                          glob_en,
    input  logic                          intr_en,
    input  logic                          intr_ack,
    output logic                          intr_pending,
    output logic                          irq
`ifdef SHA256D_NC_TSTAMP_EN
    ,
    output logic [31:0]                   head_tstamp
`endif
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = AW + 1;
    localparam int unsigned CW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
`ifdef SHA256D_NC_TSTAMP_EN
    localparam int unsigned TS_W   = 32;
`else
    localparam int unsigned TS_W   = 0;
`endif
    localparam int unsigned EW     = NONCE_W + 4 + TS_W;
    localparam logic        IRQ_ON  = 1'(IRQ_ACTIVE_LVL);
    localparam logic        IRQ_OFF = ~IRQ_ON;

    logic [CW-1:0]        r_rr;
    logic [AW-1:0]        r_rd;
    logic [AW-1:0]        r_wr;
    logic [CNT_W-1:0]     r_count;
    logic [EW-1:0]        r_head;
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic                 r_underflow;
    logic                 r_pending;
    logic                 r_irq;
`ifdef SHA256D_NC_TSTAMP_EN
    logic [31:0]          r_tstamp;
`endif

    logic [NUM_CORES-1:0] w_rot;
    logic                 w_gnt_any;
    logic [3:0]           w_gnt_idx;
    int                   w_sum;
    logic [CW-1:0]        w_rr_nxt;
    logic [NONCE_W-1:0]   w_nonce;
    logic [EW-1:0]        w_entry;
    logic                 w_push;
    logic                 w_pop;
    logic [AW-1:0]        w_rd_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    // Round-robin: rotate valids so offset 0 is the rr pointer; lowest offset wins.
    always_comb begin
        w_rot     = NUM_CORES'({hit_valid, hit_valid} >> r_rr);
        w_gnt_any = 1'b0;
        w_gnt_idx = 4'd0;
        w_sum     = 0;
        if (s00_axi_aresetn && (r_count < CNT_W'(FIFO_DEPTH))) begin
            for (int i = NUM_CORES - 1; i >= 0; i--) begin
                if (w_rot[i]) begin
                    w_gnt_any = 1'b1;
                    w_sum     = int'(r_rr) + i;
                    if (w_sum >= int'(NUM_CORES)) begin
                        w_sum = w_sum - int'(NUM_CORES);
                    end
                    w_gnt_idx = 4'(w_sum);
                end
            end
        end
    end

    assign hit_ready = w_gnt_any ? (NUM_CORES'(1) << w_gnt_idx) : '0;
    assign w_rr_nxt  = (w_gnt_idx == 4'(NUM_CORES - 1)) ? '0 : CW'(w_gnt_idx + 4'd1);
    assign w_nonce   = NONCE_W'(hit_nonce >> (int'(w_gnt_idx) * int'(NONCE_W)));

`ifdef SHA256D_NC_TSTAMP_EN
    assign w_entry = {r_tstamp, w_gnt_idx, w_nonce};
`else
    assign w_entry = {w_gnt_idx, w_nonce};
`endif

    // A pop on an empty FIFO is dropped and only flags underflow.
    assign w_push    = w_gnt_any;
    assign w_pop     = pop && (r_count != '0);
    assign w_rd_nxt  = r_rd + AW'(w_pop);
    assign w_cnt_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge s00_axi_aclk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_entry;
        end
    end

    // Pointers, occupancy and the registered FWFT head (bypasses the write when it lands at the head).
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_rr        <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_head      <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr <= w_rr_nxt;
            end
            r_rd    <= w_rd_nxt;
            r_wr    <= r_wr + AW'(w_push);
            r_count <= w_cnt_nxt;
            if (w_cnt_nxt != '0) begin
                if (w_push && (r_wr == w_rd_nxt)) begin
                    r_head <= w_entry;
                end else begin
                    r_head <= r_mem[w_rd_nxt];
                end
            end
            if (pop && (r_count == '0)) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Interrupt source: push sets pending (wins over ack); irq is the gated pending, one cycle later.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_pending <= 1'b0;
            r_irq     <= IRQ_OFF;
        end else begin
            if (w_push) begin
                r_pending <= 1'b1;
            end else if (intr_ack) begin
                r_pending <= 1'b0;
            end
            r_irq <= (glob_en && intr_en && r_pending) ? IRQ_ON : IRQ_OFF;
        end
    end

`ifdef SHA256D_NC_TSTAMP_EN
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_tstamp <= '0;
        end else begin
            r_tstamp <= r_tstamp + 32'd1;
        end
    end

    assign head_tstamp = r_head[NONCE_W+4 +: 32];
`endif

    assign head_nonce   = r_head[NONCE_W-1:0];
    assign head_core    = r_head[NONCE_W +: 4];
    assign fifo_count   = r_count;
    assign underflow    = r_underflow;
    assign intr_pending = r_pending;
    assign irq          = r_irq;

endmodule
